// File: rtl/ysyx_2022040010_cache_arbiter.sv
// Shares one burst memory port between I-cache refills and D-cache refills/writebacks.
// The D-cache wins a tie. A grant is held from IDLE until the DONE cycle, with no preemption.
module ysyx_2022040010_cache_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_avalid,
  input  logic              mem_aready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wlast,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_bvalid,
  output logic              stallreq_for_cache,
  output logic              rw_over
);
  localparam int OFF_W = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RDATA, S_WDATA, S_WRESP, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                grant_dc_q, grant_dc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_dc_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_dc_q <= grant_dc_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
    end
  end

  // A command or beat moves on a cycle where its valid and ready are both high.
  // Valid never depends on ready. The read side has no ready, so mem_rvalid alone moves a beat.
  always_comb begin
    state_d    = state_q;
    grant_dc_d = grant_dc_q;
    addr_d     = addr_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    ic_rvalid  = 1'b0;
    ic_done    = 1'b0;
    dc_wnext   = 1'b0;
    dc_rvalid  = 1'b0;
    dc_done    = 1'b0;
    rdata      = '0;
    mem_avalid = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wvalid = 1'b0;
    mem_wdata  = '0;
    mem_wlast  = 1'b0;
    rw_over    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = ic_req | dc_req;
        if (dc_req) begin
          grant_dc_d = 1'b1;
          addr_d     = dc_addr & ~OFF_MASK;
          we_d       = dc_we;
          state_d    = S_ADDR;
        end else if (ic_req) begin
          grant_dc_d = 1'b0;
          addr_d     = ic_addr & ~OFF_MASK;
          we_d       = 1'b0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        stall      = 1'b1;
        mem_avalid = 1'b1;
        mem_addr   = addr_q;
        mem_we     = we_q;
        if (mem_aready) state_d = we_q ? S_WDATA : S_RDATA;
      end
      S_RDATA: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          rdata     = mem_rdata;
          ic_rvalid = ~grant_dc_q;
          dc_rvalid = grant_dc_q;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_WDATA: begin
        stall      = 1'b1;
        mem_wvalid = 1'b1;
        mem_wdata  = dc_wdata;
        mem_wlast  = (cnt_q == LAST_BEAT);
        if (mem_wready) begin
          dc_wnext = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        stall = 1'b1;
        if (mem_bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        rw_over = 1'b1;
        ic_done = ~grant_dc_q;
        dc_done = grant_dc_q;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is masked while in reset so every output reads 0 as soon as rst rises.
  assign stallreq_for_cache = stall & ~rst;

endmodule

// File: tb/tb_ysyx_2022040010_cache_arbiter.sv
// Bench for the cache arbiter: directed scenarios, then randomized traffic.
// A transaction-level model inside the bench checks every output on every cycle.
module tb_ysyx_2022040010_cache_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int NB = 4;
  localparam logic [AW-1:0] LINE_MASK = 32'hFFFF_FFE0;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ic_req, ic_rvalid, ic_done;
  logic [AW-1:0] ic_addr;
  logic          dc_req, dc_we, dc_wnext, dc_rvalid, dc_done;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata, rdata;
  logic          mem_avalid, mem_aready, mem_we, mem_wvalid, mem_wready, mem_wlast;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rvalid, mem_bvalid, stallreq_for_cache, rw_over;

  ysyx_2022040010_cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(NB)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_done(dc_done), .rdata(rdata),
    .mem_avalid(mem_avalid), .mem_aready(mem_aready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_bvalid(mem_bvalid), .stallreq_for_cache(stallreq_for_cache), .rw_over(rw_over)
  );

  // D-cache side writeback line; the offered beat is the number of dc_wnext pulses since the request.
  logic [DW-1:0] wline [NB];
  int  wbase;
  bit  hold_dc;

  int mon_cmp, mon_err, dir_cmp, dir_err;
  int cyc, n_ic_rv, n_dc_rv, n_wnext, n_wlast_acc, n_rw_over, n_ic_done, n_dc_done;
  int ic_done_cyc, dc_done_cyc, avalid_rise_cyc;
  bit prev_avalid;

  // transaction-level model: owner, line address, direction and how far the burst has got
  bit            m_busy, m_own_d, m_wr, m_cmd, m_resp;
  int            m_beats;
  logic [AW-1:0] m_la;
  logic [DW-1:0] m_wline [NB];

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic void mchk(input string name, input logic [63:0] act, input logic [63:0] exp);
    mon_cmp++;
    if (act !== exp) begin
      mon_err++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endfunction

  task automatic lchk(input string name, input logic [63:0] act, input logic [63:0] exp);
    dir_cmp++;
    if (act !== exp) begin
      dir_err++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin : mon
    logic          e_icrv, e_icd, e_dcrv, e_dcd, e_wn, e_av, e_we, e_wv, e_wl, e_st, e_rw;
    logic [DW-1:0] e_rdata, e_wdata;
    logic [AW-1:0] e_addr;
    bit            fin;
    {e_icrv, e_icd, e_dcrv, e_dcd, e_wn, e_av, e_we, e_wv, e_wl, e_st, e_rw} = '0;
    e_rdata = '0;
    e_wdata = '0;
    e_addr  = '0;
    fin = m_busy && m_cmd && (m_beats == NB) && (!m_wr || m_resp);
    if (!rst) begin
      if (!m_busy) e_st = ic_req | dc_req;
      else if (fin) begin
        e_rw  = 1'b1;
        e_icd = !m_own_d;
        e_dcd = m_own_d;
      end else begin
        e_st = 1'b1;
        if (!m_cmd) begin
          e_av   = 1'b1;
          e_addr = m_la;
          e_we   = m_wr;
        end else if (!m_wr) begin
          if (mem_rvalid) begin
            e_rdata = mem_rdata;
            e_icrv  = !m_own_d;
            e_dcrv  = m_own_d;
          end
        end else if (m_beats < NB) begin
          e_wv    = 1'b1;
          e_wdata = m_wline[m_beats];
          e_wl    = (m_beats == NB - 1);
          e_wn    = mem_wready;
        end
      end
    end
    mchk("ctrl", {ic_rvalid, ic_done, dc_rvalid, dc_done, dc_wnext, mem_avalid, mem_we,
                  mem_wvalid, mem_wlast, stallreq_for_cache, rw_over},
                 {e_icrv, e_icd, e_dcrv, e_dcd, e_wn, e_av, e_we, e_wv, e_wl, e_st, e_rw});
    mchk("rdata", rdata, e_rdata);
    mchk("mem_addr", mem_addr, e_addr);
    mchk("mem_wdata", mem_wdata, e_wdata);

    if (ic_rvalid) n_ic_rv++;
    if (dc_rvalid) n_dc_rv++;
    if (dc_wnext) n_wnext++;
    if (mem_wvalid && mem_wready && mem_wlast) n_wlast_acc++;
    if (rw_over) n_rw_over++;
    if (ic_done) begin n_ic_done++; ic_done_cyc = cyc; end
    if (dc_done) begin n_dc_done++; dc_done_cyc = cyc; end
    if (mem_avalid && !prev_avalid) avalid_rise_cyc = cyc;
    prev_avalid = mem_avalid;

    if (rst) m_busy = 0;
    else if (!m_busy) begin
      if (dc_req || ic_req) begin
        m_busy  = 1;
        m_own_d = dc_req;
        m_la    = (dc_req ? dc_addr : ic_addr) & LINE_MASK;
        m_wr    = dc_req && dc_we;
        m_cmd   = 0;
        m_resp  = 0;
        m_beats = 0;
        for (int k = 0; k < NB; k++) m_wline[k] = wline[k];
      end
    end else if (fin) m_busy = 0;
    else if (!m_cmd) m_cmd = mem_aready;
    else if (!m_wr) m_beats += int'(mem_rvalid);
    else if (m_beats < NB) m_beats += int'(mem_wready);
    else m_resp = mem_bvalid;
    cyc++;
  end

  // driver tasks: each tick lands 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk); #1;
    if (ic_done) ic_req = 1'b0;
    if (dc_done && !hold_dc) dc_req = 1'b0;
    dc_wdata = wline[(n_wnext - wbase) & (NB - 1)];
  endtask

  task automatic ic_raise(input logic [AW-1:0] a);
    ic_req  = 1'b1;
    ic_addr = a;
  endtask

  task automatic dc_raise(input logic we, input logic [AW-1:0] a);
    for (int k = 0; k < NB; k++) wline[k] = rnd64();
    wbase    = n_wnext;
    dc_req   = 1'b1;
    dc_we    = we;
    dc_addr  = a;
    dc_wdata = wline[0];
  endtask

  task automatic mem_quiet();
    mem_aready = 0; mem_rvalid = 0; mem_wready = 0; mem_bvalid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, b0, b1, b2;
    bit got;
    logic [DW-1:0] d;
    logic [5:0] wr_pat;
    logic [6:0] rv_pat;
    wr_pat = 6'b101101;
    rv_pat = 7'b1011001;
    for (int k = 0; k < NB; k++) wline[k] = '0;
    rst = 1; hold_dc = 0;
    ic_req = 1; ic_addr = '0; dc_req = 1; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    mem_rdata = '0;
    mem_quiet();
    repeat (2) @(posedge clk);
    @(negedge clk);
    lchk("rst_stall", stallreq_for_cache, 0);
    lchk("rst_avalid", mem_avalid, 0);
    lchk("rst_rwover", rw_over, 0);
    tick(); rst = 0; ic_req = 0; dc_req = 0;
    tick();

    // 1: I-cache refill, command accepted at once, four back-to-back beats
    tick(); ic_raise(32'h8000_0014); mem_aready = 1; t0 = cyc; b0 = n_ic_rv;
    @(negedge clk); lchk("t1_req_stall", stallreq_for_cache, 1);
    tick();
    @(negedge clk);
    lchk("t1_avalid", mem_avalid, 1);
    lchk("t1_addr", mem_addr, 64'h8000_0000);
    for (int i = 0; i < NB; i++) begin
      tick(); mem_aready = 0; mem_rvalid = 1; mem_rdata = rnd64(); d = mem_rdata;
      @(negedge clk);
      lchk("t1_rvalid", ic_rvalid, 1);
      lchk("t1_rdata", rdata, d);
    end
    tick(); mem_rvalid = 0;
    @(negedge clk);
    lchk("t1_done", {ic_done, rw_over, stallreq_for_cache}, 3'b110);
    tick();
    lchk("t1_done_cyc", ic_done_cyc - t0, 6);
    lchk("t1_beats", n_ic_rv - b0, 4);
    lchk("t1_idle_stall", stallreq_for_cache, 0);

    // 2: D-cache writeback with wready gaps and a late write response
    tick(); dc_raise(1, 32'h8000_1038); mem_aready = 1; t0 = cyc; b0 = n_wnext; b1 = n_wlast_acc;
    tick();
    @(negedge clk);
    lchk("t2_addr", mem_addr, 64'h8000_1020);
    lchk("t2_we", mem_we, 1);
    for (int i = 0; i < 6; i++) begin
      tick(); mem_aready = 0; mem_wready = wr_pat[i];
      @(negedge clk);
      if (i == 4) lchk("t2_wlast_wait", {mem_wlast, dc_wnext}, 2'b10);
      if (i == 5) lchk("t2_wlast_last", {mem_wlast, dc_wnext}, 2'b11);
    end
    tick(); mem_wready = 0;
    tick(); mem_bvalid = 1;
    tick(); mem_bvalid = 0;
    @(negedge clk); lchk("t2_done", {dc_done, rw_over}, 2'b11);
    tick();
    lchk("t2_done_cyc", dc_done_cyc - t0, 10);
    lchk("t2_wnext", n_wnext - b0, 4);
    lchk("t2_wlast_acc", n_wlast_acc - b1, 1);

    // 3: simultaneous requests, D first then I
    tick(); ic_raise(32'h8000_4044); dc_raise(0, 32'h8000_5058);
    mem_aready = 1; mem_rvalid = 1; t0 = cyc; b0 = n_rw_over; b1 = n_ic_done; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(); mem_rdata = rnd64();
      if (n_ic_done > b1) got = 1;
    end
    mem_quiet();
    lchk("t3_finished", got, 1);
    lchk("t3_dc_done_cyc", dc_done_cyc - t0, 6);
    lchk("t3_ic_addr_cyc", avalid_rise_cyc - t0, 8);
    lchk("t3_ic_done_cyc", ic_done_cyc - t0, 13);
    lchk("t3_rw_over", n_rw_over - b0, 2);

    // 4: D-cache refill with rvalid gaps
    tick(); dc_raise(0, {$urandom}); mem_aready = 1; t0 = cyc; b0 = n_dc_rv;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick(); mem_aready = 0; mem_rvalid = rv_pat[i]; mem_rdata = rnd64();
    end
    tick(); mem_rvalid = 0;
    tick();
    lchk("t4_done_cyc", dc_done_cyc - t0, 9);
    lchk("t4_beats", n_dc_rv - b0, 4);

    // 5: reset on the second read beat, then a fresh request
    tick(); ic_raise(32'h8000_2000); mem_aready = 1; b0 = n_rw_over; b1 = n_ic_done;
    tick();
    tick(); mem_aready = 0; mem_rvalid = 1; mem_rdata = rnd64();
    tick(); rst = 1; mem_rdata = rnd64();
    @(negedge clk);
    lchk("t5_rst_stall", stallreq_for_cache, 0);
    lchk("t5_rst_rvalid", ic_rvalid, 0);
    lchk("t5_rst_rdata", rdata, 0);
    tick(); rst = 0; ic_req = 0; mem_rvalid = 0;
    tick();
    lchk("t5_no_done", n_rw_over - b0, 0);
    ic_raise(32'h8000_3008); mem_aready = 1; mem_rvalid = 1; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick(); mem_rdata = rnd64();
      if (n_ic_done > b1) got = 1;
    end
    mem_quiet();
    lchk("t5_served", got, 1);
    lchk("t5_rw_over", n_rw_over - b0, 1);

    // 6: D request held through DONE becomes a second transfer
    tick(); hold_dc = 1; dc_raise(0, 32'h8000_6000); mem_aready = 1; mem_rvalid = 1;
    t0 = cyc; b2 = n_dc_done;
    for (int i = 1; i <= 6; i++) begin tick(); mem_rdata = rnd64(); end
    @(negedge clk); lchk("t6_first_done", dc_done, 1);
    hold_dc = 0;
    tick();
    @(negedge clk); lchk("t6_restall", {stallreq_for_cache, mem_avalid}, 2'b10);
    tick();
    @(negedge clk); lchk("t6_addr_again", mem_avalid, 1);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick(); mem_rdata = rnd64();
      if (n_dc_done - b2 >= 2) got = 1;
    end
    mem_quiet();
    lchk("t6_second_done", got, 1);
    lchk("t6_done_cyc", dc_done_cyc - t0, 13);

    // randomized traffic with occasional resets
    tick(); b0 = n_rw_over;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1; ic_req = 0; dc_req = 0;
      end else begin
        rst = 0;
        if (!ic_req && !ic_done && $urandom_range(0, 3) == 0) ic_raise({$urandom});
        if (!dc_req && !dc_done && $urandom_range(0, 3) == 0)
          dc_raise(1'($urandom_range(0, 1)), {$urandom});
      end
      mem_aready = 1'($urandom_range(0, 1));
      mem_rvalid = ($urandom_range(0, 2) != 0);
      mem_rdata  = rnd64();
      mem_wready = 1'($urandom_range(0, 1));
      mem_bvalid = ($urandom_range(0, 3) == 0);
    end
    tick(); rst = 0; mem_quiet();
    repeat (3) tick();
    lchk("rand_progress", (n_rw_over - b0) > 30, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", mon_cmp + dir_cmp, mon_err + dir_err);
    $finish;
  end
endmodule
